c4_board_ctrl: RTL

//  Owns the Connect-4 board; sits directly upstream of the minimax AI and consumes its result.

---
 rtl/c4_pkg.sv | 32 +++
 rtl/c4_board_ctrl_if.sv | 27 ++
 rtl/c4_win_detect.sv | 36 +++
 rtl/c4_board_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared constants, state encoding and grid indexing for the Connect-4 board controller.
package c4_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int GRID_W = 2 * ROWS * COLS;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_HUMAN = 2'b01;
  localparam logic [1:0] CELL_AI    = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_HUMAN = 2'b01;
  localparam logic [1:0] WIN_AI    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam logic [2:0] FULL_COUNT = 3'd6;

  typedef enum logic [2:0] {
    ST_HUMAN,
    ST_AI,
    ST_CHECK,
    ST_HANDOFF,
    ST_OVER
  } state_t;

  // Upper bit of the 2-bit cell field; column 0 sits at the high end of each row.
  function automatic logic [6:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 7'd13 - 7'({col, 1'b0}) + 7'(row) * 7'd14;
  endfunction

endpackage

// File: rtl/c4_board_ctrl_if.sv
// Board controller bus: move requests from the human/AI side and the published board state.
interface c4_board_ctrl_if;
  import c4_pkg::*;

  logic              new_game;
  logic [2:0]        col_sel;
  logic              drop;
  logic              ai_move;
  logic [6:0]        ai_opt;
  logic [GRID_W-1:0] grid;
  logic [3*COLS-1:0] column_counts;
  logic              player;
  logic [1:0]        winner;
  logic              game_over;
  logic              illegal;

  modport master (
    output new_game, col_sel, drop, ai_move, ai_opt,
    input  grid, column_counts, player, winner, game_over, illegal
  );

  modport slave (
    input  new_game, col_sel, drop, ai_move, ai_opt,
    output grid, column_counts, player, winner, game_over, illegal
  );

endinterface

// File: rtl/c4_win_detect.sv
// Combinational four-in-a-row detector over all 69 windows for one colour.
module c4_win_detect
  import c4_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  input  logic [1:0]        colour,
  output logic              win
);

  logic [ROWS-1:0][COLS-1:0] hit;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = 13 - 2 * c + 14 * r;
      assign hit[r][c] = (grid[IDX -: 2] == colour);
    end
  end

  // Horizontal, vertical, rising and falling diagonal windows, each loop bounded to stay on the board.
  always_comb begin
    win = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c <= COLS - 4; c++)
        if (hit[r][c] && hit[r][c+1] && hit[r][c+2] && hit[r][c+3]) win = 1'b1;
    for (int r = 0; r <= ROWS - 4; r++)
      for (int c = 0; c < COLS; c++)
        if (hit[r][c] && hit[r+1][c] && hit[r+2][c] && hit[r+3][c]) win = 1'b1;
    for (int r = 0; r <= ROWS - 4; r++)
      for (int c = 0; c <= COLS - 4; c++)
        if (hit[r][c] && hit[r+1][c+1] && hit[r+2][c+2] && hit[r+3][c+3]) win = 1'b1;
    for (int r = 0; r <= ROWS - 4; r++)
      for (int c = 3; c < COLS; c++)
        if (hit[r][c] && hit[r+1][c-1] && hit[r+2][c-2] && hit[r+3][c-3]) win = 1'b1;
  end

endmodule

// File: rtl/c4_board_ctrl.sv
// Connect-4 board owner: applies human/AI moves, checks win/draw, hands the turn over.
// Define C4_AI_FALLBACK_EN to place illegal AI moves in the leftmost non-full column instead of re-requesting.
module c4_board_ctrl
  import c4_pkg::*;
#(
  parameter bit HUMAN_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  c4_board_ctrl_if.slave  bus
);

  localparam state_t START_STATE  = HUMAN_FIRST ? ST_HUMAN : ST_AI;
  localparam logic   START_PLAYER = !HUMAN_FIRST;

  state_t                   state_q, state_d;
  logic [GRID_W-1:0]        grid_q, grid_d;
  logic [COLS-1:0][2:0]     counts_q, counts_d;
  logic                     player_q, player_d;
  logic [1:0]               winner_q, winner_d;
  logic [1:0]               mover_q, mover_d;
  logic                     illegal_q, illegal_d;

  logic                     win;
  logic                     board_full;
  logic [2:0]               human_cnt;
  logic [6:0]               ai_mod;
  logic [2:0]               ai_col;
  logic [3:0]               ai_row;
  logic [2:0]               ai_cnt;
  logic                     ai_legal;
  logic                     place_en;
  logic [2:0]               place_col;
  logic [2:0]               place_row;
  logic [1:0]               place_code;
`ifdef C4_AI_FALLBACK_EN
  logic [2:0]               fb_col;
  logic [2:0]               fb_cnt;
`endif

  c4_win_detect u_win_detect (
    .grid   (grid_q),
    .colour (mover_q),
    .win    (win)
  );

  // Column lookups go through loops so that col_sel=7 simply reads as a full column.
  always_comb begin
    human_cnt  = FULL_COUNT;
    ai_cnt     = FULL_COUNT;
    board_full = 1'b1;
    ai_mod     = bus.ai_opt % 7'd14;
    ai_col     = 3'((7'd13 - ai_mod) >> 1);
    ai_row     = 4'(bus.ai_opt / 7'd14);
    for (int c = 0; c < COLS; c++) begin
      if (bus.col_sel == 3'(c)) human_cnt = counts_q[c];
      if (ai_col == 3'(c))      ai_cnt    = counts_q[c];
      if (counts_q[c] != FULL_COUNT) board_full = 1'b0;
    end
    ai_legal = (bus.ai_opt <= 7'd83) && bus.ai_opt[0] &&
               ({1'b0, ai_cnt} == ai_row) && (ai_cnt < FULL_COUNT);
  end

`ifdef C4_AI_FALLBACK_EN
  always_comb begin
    fb_col = 3'd0;
    fb_cnt = FULL_COUNT;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (counts_q[c] < FULL_COUNT) begin
        fb_col = 3'(c);
        fb_cnt = counts_q[c];
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    counts_d   = counts_q;
    player_d   = player_q;
    winner_d   = winner_q;
    mover_d    = mover_q;
    illegal_d  = 1'b0;
    place_en   = 1'b0;
    place_col  = 3'd0;
    place_row  = 3'd0;
    place_code = CELL_EMPTY;

    if (bus.new_game) begin
      state_d  = START_STATE;
      grid_d   = '0;
      counts_d = '0;
      player_d = START_PLAYER;
      winner_d = WIN_NONE;
      mover_d  = CELL_EMPTY;
    end else begin
      unique case (state_q)
        ST_HUMAN: begin
          if (bus.drop) begin
            if (human_cnt < FULL_COUNT) begin
              place_en   = 1'b1;
              place_col  = bus.col_sel;
              place_row  = human_cnt;
              place_code = CELL_HUMAN;
              state_d    = ST_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        ST_AI: begin
          if (bus.ai_move) begin
            if (ai_legal) begin
              place_en   = 1'b1;
              place_col  = ai_col;
              place_row  = ai_cnt;
              place_code = CELL_AI;
              state_d    = ST_CHECK;
            end else begin
              illegal_d = 1'b1;
`ifdef C4_AI_FALLBACK_EN
              place_en   = 1'b1;
              place_col  = fb_col;
              place_row  = fb_cnt;
              place_code = CELL_AI;
              state_d    = ST_CHECK;
`else
              player_d = 1'b0;
              state_d  = ST_HANDOFF;
`endif
            end
          end
        end
        // Player is held through CHECK; it only moves once the outcome is known.
        ST_CHECK: begin
          if (win) begin
            winner_d = mover_q;
            player_d = 1'b0;
            state_d  = ST_OVER;
          end else if (board_full) begin
            winner_d = WIN_DRAW;
            player_d = 1'b0;
            state_d  = ST_OVER;
          end else if (mover_q == CELL_HUMAN) begin
            player_d = 1'b1;
            state_d  = ST_AI;
          end else begin
            player_d = 1'b0;
            state_d  = ST_HUMAN;
          end
        end
        ST_HANDOFF: begin
          player_d = 1'b1;
          state_d  = ST_AI;
        end
        ST_OVER: begin
          player_d = 1'b0;
        end
        default: begin
          state_d = START_STATE;
        end
      endcase
    end

    if (place_en) begin
      grid_d[cell_idx(place_row, place_col) -: 2] = place_code;
      mover_d = place_code;
      for (int c = 0; c < COLS; c++)
        if (place_col == 3'(c)) counts_d[c] = counts_q[c] + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= START_STATE;
      grid_q    <= '0;
      counts_q  <= '0;
      player_q  <= START_PLAYER;
      winner_q  <= WIN_NONE;
      mover_q   <= CELL_EMPTY;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      counts_q  <= counts_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      mover_q   <= mover_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.grid          = grid_q;
  assign bus.column_counts = counts_q;
  assign bus.player        = player_q;
  assign bus.winner        = winner_q;
  assign bus.game_over     = (state_q == ST_OVER);
  assign bus.illegal       = illegal_q;

endmodule
